// File: rtl/spawn_request_queue.sv
// spawn_request_queue: turns software-written spawn codes on a level PIO port
// into single queued requests, presented one at a time to the game logic.
// A request is a change of spawn_in to a nonzero value; repeats of the same
// code produce nothing until the port goes through a different value.
// Optional feature: define SPAWN_RATE_LIMIT_EN to allow at most one pop per
// frame_tick (the first pop after reset is free).
module spawn_request_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TYPE_W = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [TYPE_W-1:0]            spawn_in,
  input  logic                         frame_tick,
  input  logic                         spawn_ready,
  input  logic                         overflow_clr,
  output logic                         spawn_valid,
  output logic [TYPE_W-1:0]            spawn_type,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TYPE_W-1:0] mem [DEPTH];
  logic [TYPE_W-1:0] prev_q;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic              capture_c;
  logic              pop_c;
  logic              full_c;
  logic              push_c;
  logic              drop_c;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  count_after_pop;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [TYPE_W-1:0] head_nxt;
  logic              overflow_nxt;
  logic              valid_nxt;
  logic [TYPE_W-1:0] type_nxt;
  logic              token_nxt;

`ifdef SPAWN_RATE_LIMIT_EN
  logic token;

  // Frame token: refilled by frame_tick, spent by a pop; refill wins.
  always_comb begin
    token_nxt = token;
    if (frame_tick) begin
      token_nxt = 1'b1;
    end else if (pop_c) begin
      token_nxt = 1'b0;
    end
  end

  // Token register; starts full so the first request is not delayed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      token <= 1'b1;
    end else begin
      token <= token_nxt;
    end
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign token_nxt         = 1'b1;
`endif

  // Request detection, push/pop arbitration and next head presentation.
  always_comb begin
    capture_c       = (spawn_in != prev_q) && (spawn_in != '0);
    pop_c           = spawn_valid && spawn_ready;
    full_c          = (count == CNT_W'(DEPTH));
    push_c          = capture_c && (!full_c || pop_c);
    drop_c          = capture_c && full_c && !pop_c;
    count_after_pop = count - CNT_W'(pop_c);
    count_nxt       = count_after_pop + CNT_W'(push_c);
    rd_ptr_nxt      = pop_c  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_nxt      = push_c ? wr_ptr + PTR_W'(1) : wr_ptr;

    // An entry pushed into a queue that is empty after this pop is not in
    // the array yet, so it is forwarded straight to the head.
    head_nxt = mem[rd_ptr_nxt];
    if (push_c && (count_after_pop == '0)) begin
      head_nxt = spawn_in;
    end

    overflow_nxt = overflow;
    if (drop_c) begin
      overflow_nxt = 1'b1;
    end else if (overflow_clr) begin
      overflow_nxt = 1'b0;
    end

    valid_nxt = (count_nxt != '0) && token_nxt;
    type_nxt  = (count_nxt != '0) ? head_nxt : '0;
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= spawn_in;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_type  <= '0;
    end else begin
      prev_q      <= spawn_in;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      overflow    <= overflow_nxt;
      spawn_valid <= valid_nxt;
      spawn_type  <= type_nxt;
    end
  end

endmodule

// File: tb/tb_spawn_request_queue.sv
// Testbench for spawn_request_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a pop scoreboard.
module tb_spawn_request_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TYPE_W = 3;
`ifdef SPAWN_RATE_LIMIT_EN
  localparam bit RATE = 1'b1;
`else
  localparam bit RATE = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [TYPE_W-1:0]       spawn_in;
  logic                    frame_tick;
  logic                    spawn_ready;
  logic                    overflow_clr;
  logic                    spawn_valid;
  logic [TYPE_W-1:0]       spawn_type;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;

  spawn_request_queue #(.DEPTH(DEPTH), .TYPE_W(TYPE_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spawn_in     (spawn_in),
    .frame_tick   (frame_tick),
    .spawn_ready  (spawn_ready),
    .overflow_clr (overflow_clr),
    .spawn_valid  (spawn_valid),
    .spawn_type   (spawn_type),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int mq[$];
  int sb[$];
  int mprev;
  bit movf;
  bit mtok;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic bit model_valid();
    return (mq.size() != 0) && (!RATE || mtok);
  endfunction

  function automatic void model_reset();
    mq.delete();
    sb.delete();
    mprev = 0;
    movf  = 1'b0;
    mtok  = 1'b1;
  endfunction

  // One clock of the specified behaviour, evaluated on pre-edge values.
  function automatic void model_step(input int code, input bit rdy, input bit tick, input bit clr);
    bit pop;
    bit cap;
    bit dropped;
    pop     = model_valid() && rdy;
    cap     = (code != mprev) && (code != 0);
    dropped = 1'b0;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() >= DEPTH) dropped = 1'b1;
      else begin
        mq.push_back(code);
        sb.push_back(code);
      end
    end
    if (dropped) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (tick) mtok = 1'b1;
    else if (pop) mtok = 1'b0;
    mprev = code;
  endfunction

  function automatic void check_all();
    chk("count", int'(count), mq.size());
    chk("spawn_valid", int'(spawn_valid), int'(model_valid()));
    chk("spawn_type", int'(spawn_type), (mq.size() != 0) ? mq[0] : 0);
    chk("overflow", int'(overflow), int'(movf));
  endfunction

  // Pop monitor: every accepted head must be the oldest outstanding request.
  always @(posedge clk) begin
    if (reset_n && spawn_valid && spawn_ready) begin
      if (sb.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("pop_order", int'(spawn_type), sb.pop_front());
    end
  end

  // Called at a falling edge: drive, step model, clock, compare.
  task automatic cyc(input int code, input bit rdy, input bit tick, input bit clr);
    spawn_in     = TYPE_W'(code);
    spawn_ready  = rdy;
    frame_tick   = tick;
    overflow_clr = clr;
    model_step(code, rdy, tick, clr);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic fill(input int n, input bit tick);
    for (int i = 1; i <= n; i++) begin
      cyc(i, 1'b0, tick, 1'b0);
      cyc(0, 1'b0, tick, 1'b0);
    end
  endtask

  int pct;
  int code;
  int last;

  initial begin
    reset_n      = 1'b0;
    spawn_in     = '0;
    frame_tick   = 1'b0;
    spawn_ready  = 1'b0;
    overflow_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all();

    // Single request with a ready consumer
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(5, 1'b1, 1'b0, 1'b0);
    chk("single_valid", int'(spawn_valid), 1);
    chk("single_type", int'(spawn_type), 5);
    cyc(5, 1'b1, 1'b0, 1'b0);
    chk("single_drained", int'(count), 0);

    // Held code produces one request
    do_reset();
    cyc(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(3, 1'b0, 1'b0, 1'b0);
    chk("held_count", int'(count), 1);

    // Overflow on the fifth request, then FIFO drain
    do_reset();
    fill(5, 1'b0);
    chk("ovf_count", int'(count), 4);
    chk("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 6; i++) cyc(0, 1'b1, 1'b1, 1'b0);
    chk("ovf_drained", int'(count), 0);
    cyc(0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", int'(overflow), 0);

    // Push and pop together while full
    do_reset();
    fill(4, 1'b0);
    cyc(6, 1'b1, 1'b1, 1'b0);
    chk("full_pushpop_count", int'(count), 4);
    chk("full_pushpop_ovf", int'(overflow), 0);
    for (int i = 0; i < 6; i++) cyc(0, 1'b1, 1'b1, 1'b0);

`ifdef SPAWN_RATE_LIMIT_EN
    // One pop per frame after the first
    do_reset();
    fill(3, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0);
    chk("rate_first_pop", int'(count), 2);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 1'b0);
    chk("rate_held", int'(count), 2);
    cyc(0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0);
    chk("rate_second_pop", int'(count), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 1'b0);
    chk("rate_held2", int'(count), 1);
`endif

    // Asynchronous reset with entries queued
    do_reset();
    fill(3, 1'b0);
    chk("pre_reset_count", int'(count), 3);
    do_reset();

    // Random traffic
    last = 0;
    pct  = 50;
    for (int n = 0; n < 2000; n++) begin
      if (n % 200 == 0) pct = (pct == 20) ? 85 : 20;
      if (n % 600 == 599) do_reset();
      if ($urandom_range(0, 3) == 0) code = 0;
      else if ($urandom_range(0, 1) == 1) code = last;
      else code = $urandom_range(1, (1 << TYPE_W) - 1);
      last = code;
      cyc(code, $urandom_range(0, 99) < pct, $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
